interrupt_controller: RTL and testbench

Prioritising interrupt controller sitting directly upstream of the control unit. It drives the hardwareInterrupt (non-maskable) and maskableInterrupt request lines into the CU. It also supplies a 9-bit service vector that the CU places on its ramAddress output toward the trap mux. It latches edge-triggered requests, applies a software-written enable mask, and tracks the acknowledge/return handshake with the CU.

---
 rtl/interrupt_controller.sv | 264 ++++++++++++++++++++++++++
 tb/tb_interrupt_controller.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// ---------------------------------------------------------------------------
// interrupt_controller
//
// Prioritising interrupt controller in front of the control unit (CU).
// Rising edges on the request lines are latched as pending bits. A
// software-written mask gates which maskable lines may be arbitrated. The
// controller then presents one request to the CU and follows the CU's
// acknowledge/return handshake.
//
// Handshake (REQUEST -> SERVICE -> IDLE):
//   A request is presented on hardwareInterrupt (NMI) or maskableInterrupt
//   (IRQ), together with a stable intVector/intId, for as long as the
//   controller is in REQUEST.
//   A one-cycle intAck in REQUEST takes the request: the selected pending
//   bit clears, the request drops and inService rises.
//   A one-cycle intDone in SERVICE ends the handler.
//   intAck outside REQUEST and intDone outside SERVICE have no effect.
//
// Optional feature (macro NESTED_NMI_EN):
//   When defined, a pending NMI preempts an active maskable handler. One
//   saved-context bit (plus the interrupted IRQ id) lets the NMI's intDone
//   resume the maskable SERVICE. An NMI arriving during NMI service is
//   latched but does not nest.
//   When undefined, an NMI during SERVICE waits in nmiPending until IDLE.
//
// Ports:
//   Clk               in   system clock, rising edge
//   reset             in   asynchronous active-high reset
//   irqLine[N]        in   maskable request lines, rising-edge triggered
//   nmiLine           in   non-maskable request line, rising-edge triggered
//   maskWrite         in   load enable for the mask register
//   maskData[N]       in   new mask value (1 = line enabled)
//   intAck            in   CU pulse: request taken
//   intDone           in   CU pulse: return from handler
//   hardwareInterrupt out  NMI request to CU
//   maskableInterrupt out  maskable request to CU
//   intVector[9]      out  handler address of the presented request
//   intId[ID_W]       out  index of the presented IRQ (0 for NMI)
//   pendingOut[N]     out  current pending bits
//   inService         out  high while a handler is active
// ---------------------------------------------------------------------------
module interrupt_controller #(
  parameter int          NUM_IRQ     = 4,
  parameter logic [8:0]  VECTOR_BASE = 9'h100,
  parameter int          ID_W        = 3
) (
  input  logic               Clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irqLine,
  input  logic               nmiLine,
  input  logic               maskWrite,
  input  logic [NUM_IRQ-1:0] maskData,
  input  logic               intAck,
  input  logic               intDone,
  output logic               hardwareInterrupt,
  output logic               maskableInterrupt,
  output logic [8:0]         intVector,
  output logic [ID_W-1:0]    intId,
  output logic [NUM_IRQ-1:0] pendingOut,
  output logic               inService
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } state_t;

  // State registers
  state_t             state_q, state_d;
  logic               sel_nmi_q, sel_nmi_d;
  logic [ID_W-1:0]    sel_id_q, sel_id_d;
  logic [NUM_IRQ-1:0] prev_irq_q;
  logic               prev_nmi_q;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic               nmi_pend_q, nmi_pend_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
`ifdef NESTED_NMI_EN
  logic               nested_q, nested_d;
  logic [ID_W-1:0]    saved_id_q, saved_id_d;
`endif

  // Registered outputs
  logic               hw_q, hw_d;
  logic               mi_q, mi_d;
  logic [8:0]         vec_q, vec_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               svc_q, svc_d;

  // Combinational helpers
  logic [NUM_IRQ-1:0] irq_rise;
  logic               nmi_rise;
  logic [NUM_IRQ-1:0] eligible;
  logic               low_found;
  logic [ID_W-1:0]    low_id;
  logic               sel_mask_en;
  logic               ack_take;
  logic [NUM_IRQ-1:0] clr_irq;

  assign irq_rise = irqLine & ~prev_irq_q;
  assign nmi_rise = nmiLine & ~prev_nmi_q;
  assign eligible = pending_q & mask_q;
  assign ack_take = (state_q == REQUEST) && intAck;

  // Lowest set index wins: scan downward so the last hit is the lowest.
  always_comb begin
    low_found = 1'b0;
    low_id    = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        low_found = 1'b1;
        low_id    = ID_W'(i);
      end
    end
  end

  // Mask bit of the frozen selection, and the pending bit an ack clears.
  always_comb begin
    sel_mask_en = 1'b0;
    clr_irq     = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (sel_id_q == ID_W'(i)) begin
        sel_mask_en = mask_q[i];
        clr_irq[i]  = ack_take && !sel_nmi_q;
      end
    end
  end

  // A fresh edge in the same cycle as the ack's clear keeps the bit set.
  assign pending_d  = (pending_q & ~clr_irq) | irq_rise;
  assign nmi_pend_d = (nmi_pend_q & ~(ack_take && sel_nmi_q)) | nmi_rise;
  assign mask_d     = maskWrite ? maskData : mask_q;

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    sel_nmi_d = sel_nmi_q;
    sel_id_d  = sel_id_q;
`ifdef NESTED_NMI_EN
    nested_d   = nested_q;
    saved_id_d = saved_id_q;
`endif
    case (state_q)
      IDLE: begin
        if (nmi_pend_q) begin
          state_d   = REQUEST;
          sel_nmi_d = 1'b1;
          sel_id_d  = '0;
        end else if (low_found) begin
          state_d   = REQUEST;
          sel_nmi_d = 1'b0;
          sel_id_d  = low_id;
        end
      end
      REQUEST: begin
        // An ack wins over a mask change seen in the same cycle: the CU has
        // already committed to the handler.
        if (intAck) begin
          state_d = SERVICE;
        end else if (!sel_nmi_q && !sel_mask_en) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (intDone) begin
`ifdef NESTED_NMI_EN
          if (nested_q) begin
            // NMI handler finished: resume the interrupted maskable handler.
            state_d   = SERVICE;
            sel_nmi_d = 1'b0;
            sel_id_d  = saved_id_q;
            nested_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
`ifdef NESTED_NMI_EN
        else if (nmi_pend_q && !sel_nmi_q) begin
          state_d    = REQUEST;
          sel_nmi_d  = 1'b1;
          sel_id_d   = '0;
          saved_id_d = sel_id_q;
          nested_d   = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore decode of the next state, so the output registers always reflect
  // the state register one-for-one.
  always_comb begin
    hw_d  = (state_d == REQUEST) && sel_nmi_d;
    mi_d  = (state_d == REQUEST) && !sel_nmi_d;
    vec_d = '0;
    id_d  = '0;
    if (state_d == REQUEST) begin
      if (sel_nmi_d) begin
        vec_d = VECTOR_BASE;
      end else begin
        // 9-bit add wraps modulo 512 by construction.
        vec_d = VECTOR_BASE + ((9'(sel_id_d) + 9'd1) << 2);
        id_d  = sel_id_d;
      end
    end
`ifdef NESTED_NMI_EN
    svc_d = (state_d == SERVICE) || nested_d;
`else
    svc_d = (state_d == SERVICE);
`endif
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      sel_nmi_q  <= 1'b0;
      sel_id_q   <= '0;
      prev_irq_q <= '0;
      prev_nmi_q <= 1'b0;
      pending_q  <= '0;
      nmi_pend_q <= 1'b0;
      mask_q     <= '0;
`ifdef NESTED_NMI_EN
      nested_q   <= 1'b0;
      saved_id_q <= '0;
`endif
      hw_q       <= 1'b0;
      mi_q       <= 1'b0;
      vec_q      <= '0;
      id_q       <= '0;
      svc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_nmi_q  <= sel_nmi_d;
      sel_id_q   <= sel_id_d;
      prev_irq_q <= irqLine;
      prev_nmi_q <= nmiLine;
      pending_q  <= pending_d;
      nmi_pend_q <= nmi_pend_d;
      mask_q     <= mask_d;
`ifdef NESTED_NMI_EN
      nested_q   <= nested_d;
      saved_id_q <= saved_id_d;
`endif
      hw_q       <= hw_d;
      mi_q       <= mi_d;
      vec_q      <= vec_d;
      id_q       <= id_d;
      svc_q      <= svc_d;
    end
  end

  assign hardwareInterrupt = hw_q;
  assign maskableInterrupt = mi_q;
  assign intVector         = vec_q;
  assign intId             = id_q;
  assign pendingOut        = pending_q;
  assign inService         = svc_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// ---------------------------------------------------------------------------
// tb_interrupt_controller
//
// Directed bench for interrupt_controller. A table of per-cycle input/expected
// records is applied one clock at a time, followed by a hand-written
// reset-during-REQUEST sequence. Inputs change on the falling edge and outputs
// are sampled 1 time unit after the rising edge.
//
// Expected output bundle layout (19 bits):
//   {hardwareInterrupt, maskableInterrupt, intVector[8:0], intId[2:0],
//    pendingOut[3:0], inService}
// ---------------------------------------------------------------------------
module tb_interrupt_controller;

  localparam int W = 19;

  // Clock / reset
  logic Clk   = 1'b0;
  logic reset = 1'b0;
  always #5 Clk = ~Clk;

  // DUT signals
  logic [3:0] irqLine   = '0;
  logic       nmiLine   = 1'b0;
  logic       maskWrite = 1'b0;
  logic [3:0] maskData  = '0;
  logic       intAck    = 1'b0;
  logic       intDone   = 1'b0;
  logic       hardwareInterrupt;
  logic       maskableInterrupt;
  logic [8:0] intVector;
  logic [2:0] intId;
  logic [3:0] pendingOut;
  logic       inService;

  interrupt_controller #(
    .NUM_IRQ    (4),
    .VECTOR_BASE(9'h100),
    .ID_W       (3)
  ) dut (
    .Clk              (Clk),
    .reset            (reset),
    .irqLine          (irqLine),
    .nmiLine          (nmiLine),
    .maskWrite        (maskWrite),
    .maskData         (maskData),
    .intAck           (intAck),
    .intDone          (intDone),
    .hardwareInterrupt(hardwareInterrupt),
    .maskableInterrupt(maskableInterrupt),
    .intVector        (intVector),
    .intId            (intId),
    .pendingOut       (pendingOut),
    .inService        (inService)
  );

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] irq;
    logic       nmi;
    logic       mw;
    logic [3:0] md;
    logic       ack;
    logic       done;
    logic       e_hw;
    logic       e_mi;
    logic [8:0] e_vec;
    logic [2:0] e_id;
    logic [3:0] e_pend;
    logic       e_svc;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t row(
    input logic [3:0] irq, input logic nmi, input logic mw, input logic [3:0] md,
    input logic ack, input logic done,
    input logic e_hw, input logic e_mi, input logic [8:0] e_vec,
    input logic [2:0] e_id, input logic [3:0] e_pend, input logic e_svc);
    vec_t r;
    r.irq = irq; r.nmi = nmi; r.mw = mw; r.md = md; r.ack = ack; r.done = done;
    r.e_hw = e_hw; r.e_mi = e_mi; r.e_vec = e_vec; r.e_id = e_id;
    r.e_pend = e_pend; r.e_svc = e_svc;
    return r;
  endfunction

  function automatic logic [W-1:0] actual();
    return {hardwareInterrupt, maskableInterrupt, intVector, intId, pendingOut, inService};
  endfunction

  task automatic check(input string name);
    logic [W-1:0] exp_v;
    logic [W-1:0] act_v;
    if (exp_q.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    exp_v = exp_q.pop_front();
    act_v = actual();
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got hw=%b mi=%b vec=%h id=%0d pend=%b svc=%b, want hw=%b mi=%b vec=%h id=%0d pend=%b svc=%b",
               name, act_v[18], act_v[17], act_v[16:8], act_v[7:5], act_v[4:1], act_v[0],
               exp_v[18], exp_v[17], exp_v[16:8], exp_v[7:5], exp_v[4:1], exp_v[0]);
    end
  endtask

  // Driver: change inputs on the falling edge, sample after the rising edge.
  task automatic drive(input logic [3:0] irq, input logic nmi, input logic mw,
                       input logic [3:0] md, input logic ack, input logic done);
    @(negedge Clk);
    irqLine = irq; nmiLine = nmi; maskWrite = mw; maskData = md;
    intAck = ack; intDone = done;
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_out(input logic hw, input logic mi, input logic [8:0] vec,
                            input logic [2:0] id, input logic [3:0] pend, input logic svc);
    exp_q.push_back({hw, mi, vec, id, pend, svc});
  endtask

  initial begin
    // ---------------- vector table ----------------
    //             irq    nmi  mw  md     ack done  hw mi vec     id    pend   svc
    // Two lines rise together: lowest (IRQ1) first, then IRQ2.
    tv.push_back(row(4'h0, 0, 1, 4'hF, 0, 0,   0, 0, 9'h000, 3'd0, 4'h0, 0)); // 0
    tv.push_back(row(4'h6, 0, 0, 4'h0, 0, 0,   0, 0, 9'h000, 3'd0, 4'h6, 0)); // 1
    tv.push_back(row(4'h6, 0, 0, 4'h0, 0, 0,   0, 1, 9'h108, 3'd1, 4'h6, 0)); // 2
    tv.push_back(row(4'h6, 0, 0, 4'h0, 1, 0,   0, 0, 9'h000, 3'd0, 4'h4, 1)); // 3
    tv.push_back(row(4'h0, 0, 0, 4'h0, 0, 1,   0, 0, 9'h000, 3'd0, 4'h4, 0)); // 4
    tv.push_back(row(4'h0, 0, 0, 4'h0, 0, 0,   0, 1, 9'h10C, 3'd2, 4'h4, 0)); // 5
    tv.push_back(row(4'h0, 0, 0, 4'h0, 1, 0,   0, 0, 9'h000, 3'd0, 4'h0, 1)); // 6
    tv.push_back(row(4'h0, 0, 0, 4'h0, 0, 1,   0, 0, 9'h000, 3'd0, 4'h0, 0)); // 7
    // NMI and IRQ0 together: NMI first, intDone ignored in REQUEST.
    tv.push_back(row(4'h1, 1, 1, 4'h1, 0, 0,   0, 0, 9'h000, 3'd0, 4'h1, 0)); // 8
    tv.push_back(row(4'h1, 1, 0, 4'h0, 0, 0,   1, 0, 9'h100, 3'd0, 4'h1, 0)); // 9
    tv.push_back(row(4'h1, 1, 0, 4'h0, 0, 1,   1, 0, 9'h100, 3'd0, 4'h1, 0)); // 10
    tv.push_back(row(4'h1, 1, 0, 4'h0, 1, 0,   0, 0, 9'h000, 3'd0, 4'h1, 1)); // 11
    tv.push_back(row(4'h0, 0, 0, 4'h0, 0, 1,   0, 0, 9'h000, 3'd0, 4'h1, 0)); // 12
    tv.push_back(row(4'h0, 0, 0, 4'h0, 0, 0,   0, 1, 9'h104, 3'd0, 4'h1, 0)); // 13
    tv.push_back(row(4'h0, 0, 0, 4'h0, 1, 0,   0, 0, 9'h000, 3'd0, 4'h0, 1)); // 14
    tv.push_back(row(4'h0, 0, 0, 4'h0, 1, 0,   0, 0, 9'h000, 3'd0, 4'h0, 1)); // 15 ack in SERVICE
    tv.push_back(row(4'h0, 0, 0, 4'h0, 0, 1,   0, 0, 9'h000, 3'd0, 4'h0, 0)); // 16
    tv.push_back(row(4'h0, 0, 0, 4'h0, 1, 0,   0, 0, 9'h000, 3'd0, 4'h0, 0)); // 17 ack in IDLE
    // Masked line latches, enabled later; mask write with ack.
    tv.push_back(row(4'h8, 0, 1, 4'h0, 0, 0,   0, 0, 9'h000, 3'd0, 4'h8, 0)); // 18
    tv.push_back(row(4'h8, 0, 0, 4'h0, 0, 0,   0, 0, 9'h000, 3'd0, 4'h8, 0)); // 19
    tv.push_back(row(4'h8, 0, 1, 4'h8, 0, 0,   0, 0, 9'h000, 3'd0, 4'h8, 0)); // 20
    tv.push_back(row(4'h8, 0, 0, 4'h0, 0, 0,   0, 1, 9'h110, 3'd3, 4'h8, 0)); // 21
    tv.push_back(row(4'h8, 0, 1, 4'h0, 1, 0,   0, 0, 9'h000, 3'd0, 4'h0, 1)); // 22
    tv.push_back(row(4'h0, 0, 0, 4'h0, 0, 1,   0, 0, 9'h000, 3'd0, 4'h0, 0)); // 23
    // Mask withdrawn while IRQ1 is requested.
    tv.push_back(row(4'h2, 0, 1, 4'h2, 0, 0,   0, 0, 9'h000, 3'd0, 4'h2, 0)); // 24
    tv.push_back(row(4'h2, 0, 0, 4'h0, 0, 0,   0, 1, 9'h108, 3'd1, 4'h2, 0)); // 25
    tv.push_back(row(4'h2, 0, 1, 4'h0, 0, 0,   0, 1, 9'h108, 3'd1, 4'h2, 0)); // 26
    tv.push_back(row(4'h2, 0, 0, 4'h0, 0, 0,   0, 0, 9'h000, 3'd0, 4'h2, 0)); // 27
    tv.push_back(row(4'h2, 0, 0, 4'h0, 0, 0,   0, 0, 9'h000, 3'd0, 4'h2, 0)); // 28
    // New IRQ1 edge in the ack cycle: set wins, re-requested after done.
    tv.push_back(row(4'h0, 0, 1, 4'h2, 0, 0,   0, 0, 9'h000, 3'd0, 4'h2, 0)); // 29
    tv.push_back(row(4'h0, 0, 0, 4'h0, 0, 0,   0, 1, 9'h108, 3'd1, 4'h2, 0)); // 30
    tv.push_back(row(4'h2, 0, 0, 4'h0, 1, 0,   0, 0, 9'h000, 3'd0, 4'h2, 1)); // 31
    tv.push_back(row(4'h0, 0, 0, 4'h0, 0, 1,   0, 0, 9'h000, 3'd0, 4'h2, 0)); // 32
    tv.push_back(row(4'h0, 0, 0, 4'h0, 0, 0,   0, 1, 9'h108, 3'd1, 4'h2, 0)); // 33
    // NMI edge during maskable SERVICE.
    tv.push_back(row(4'h0, 1, 0, 4'h0, 1, 0,   0, 0, 9'h000, 3'd0, 4'h0, 1)); // 34
`ifdef NESTED_NMI_EN
    tv.push_back(row(4'h0, 1, 0, 4'h0, 0, 0,   1, 0, 9'h100, 3'd0, 4'h0, 1)); // 35 preempt
    tv.push_back(row(4'h0, 1, 0, 4'h0, 1, 0,   0, 0, 9'h000, 3'd0, 4'h0, 1)); // 36
    tv.push_back(row(4'h0, 0, 0, 4'h0, 0, 1,   0, 0, 9'h000, 3'd0, 4'h0, 1)); // 37 back to IRQ1
    tv.push_back(row(4'h0, 0, 0, 4'h0, 0, 1,   0, 0, 9'h000, 3'd0, 4'h0, 0)); // 38
    tv.push_back(row(4'h0, 0, 0, 4'h0, 0, 0,   0, 0, 9'h000, 3'd0, 4'h0, 0)); // 39
`else
    tv.push_back(row(4'h0, 1, 0, 4'h0, 0, 0,   0, 0, 9'h000, 3'd0, 4'h0, 1)); // 35 waits
    tv.push_back(row(4'h0, 1, 0, 4'h0, 0, 1,   0, 0, 9'h000, 3'd0, 4'h0, 0)); // 36
    tv.push_back(row(4'h0, 1, 0, 4'h0, 0, 0,   1, 0, 9'h100, 3'd0, 4'h0, 0)); // 37
    tv.push_back(row(4'h0, 1, 0, 4'h0, 1, 0,   0, 0, 9'h000, 3'd0, 4'h0, 1)); // 38
    tv.push_back(row(4'h0, 0, 0, 4'h0, 0, 1,   0, 0, 9'h000, 3'd0, 4'h0, 0)); // 39
`endif

    // ---------------- reset state ----------------
    #1 reset = 1'b1;
    #2;
    expect_out(0, 0, 9'h000, 3'd0, 4'h0, 0);
    check("reset_state");
    @(negedge Clk);
    @(negedge Clk);
    reset = 1'b0;

    // ---------------- table ----------------
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].irq, tv[i].nmi, tv[i].mw, tv[i].md, tv[i].ack, tv[i].done);
      expect_out(tv[i].e_hw, tv[i].e_mi, tv[i].e_vec, tv[i].e_id, tv[i].e_pend, tv[i].e_svc);
      check($sformatf("row%0d", i));
    end

    // ---------------- reset during REQUEST ----------------
    drive(4'h0, 0, 1, 4'hF, 0, 0);
    drive(4'h1, 0, 0, 4'h0, 0, 0);
    drive(4'h1, 0, 0, 4'h0, 0, 0);
    expect_out(0, 1, 9'h104, 3'd0, 4'h1, 0);
    check("pre_reset_request");
    #1 reset = 1'b1;
    #1;
    expect_out(0, 0, 9'h000, 3'd0, 4'h0, 0);
    check("async_reset_outputs");
    @(negedge Clk);
    reset   = 1'b0;
    irqLine = 4'h0;
    @(posedge Clk);
    #1;
    expect_out(0, 0, 9'h000, 3'd0, 4'h0, 0);
    check("post_reset_idle");
    // Mask must be cleared: a new edge latches but is never requested.
    drive(4'h4, 0, 0, 4'h0, 0, 0);
    expect_out(0, 0, 9'h000, 3'd0, 4'h4, 0);
    check("post_reset_latch");
    drive(4'h4, 0, 0, 4'h0, 0, 0);
    drive(4'h0, 0, 0, 4'h0, 0, 0);
    expect_out(0, 0, 9'h000, 3'd0, 4'h4, 0);
    check("post_reset_mask_zero");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
